// File: rtl/box_draw_scheduler_if.sv
// box_draw_scheduler_if: requester handshake and framebuffer pixel port of box_draw_scheduler
interface box_draw_scheduler_if #(
    parameter int NBOX = 8,
    parameter int nX = 10,
    parameter int nY = 9
);
    logic [NBOX-1:0] req;
    logic [9*NBOX-1:0] req_color;
    logic [NBOX-1:0] ack;
    logic busy;
    logic [2:0] grant_id;
    logic [nX-1:0] x;
    logic [nY-1:0] y;
    logic [8:0] color;
    logic write;
    modport master (input req, req_color, output ack, busy, grant_id, x, y, color, write);
    modport slave (output req, req_color, input ack, busy, grant_id, x, y, color, write);
endinterface

// File: rtl/box_draw_scheduler.sv
// box_draw_scheduler: round-robin box-fill pixel sequencer for vga_adapter; CLEAR_SCREEN_EN adds a reset-time screen clear
module box_draw_scheduler #(
    parameter int nX = 10,
    parameter int nY = 9,
    parameter int NBOX = 8,
    parameter int BOX_SIZE = 32,
    parameter int X_FIRST = 40,
    parameter int X_PITCH = 80,
    parameter int Y_CENTER = 240,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input logic clock,
    input logic reset,
    box_draw_scheduler_if.master bus
);
    localparam int B = $clog2(BOX_SIZE);
    localparam logic [nY-1:0] OY = nY'(Y_CENTER - BOX_SIZE / 2);
`ifdef CLEAR_SCREEN_EN
    typedef enum logic [1:0] {IDLE, DRAW, ACK, CLEAR} state_t;
    localparam state_t RST_STATE = CLEAR;
    logic [nX-1:0] px, px_n;
    logic [nY-1:0] py, py_n;
`else
    typedef enum logic [1:0] {IDLE, DRAW, ACK} state_t;
    localparam state_t RST_STATE = IDLE;
`endif
    state_t state, state_n;
    logic [2:0] ptr, ptr_n, gid_n, pick, j;
    logic hit;
    logic [8:0] col, col_n, color_n;
    logic [nX-1:0] ox, ox_n, x_n;
    logic [nY-1:0] y_n;
    logic [B-1:0] cx, cx_n, cy, cy_n;
    logic [NBOX-1:0] ack_n;
    logic write_n;
    // Descending scan so the last hit kept is the first set bit at or above ptr
    always_comb begin
        pick = '0;
        hit = 1'b0;
        j = '0;
        for (int k = NBOX - 1; k >= 0; k--) begin
            j = 3'((int'(ptr) + k) % NBOX);
            if (bus.req[j]) begin
                hit = 1'b1;
                pick = j;
            end
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        gid_n = bus.grant_id;
        col_n = col;
        ox_n = ox;
        cx_n = cx;
        cy_n = cy;
        x_n = bus.x;
        y_n = bus.y;
        color_n = bus.color;
        write_n = 1'b0;
        ack_n = '0;
`ifdef CLEAR_SCREEN_EN
        px_n = px;
        py_n = py;
`endif
        case (state)
            IDLE: if (hit) begin
                state_n = DRAW;
                gid_n = pick;
                col_n = bus.req_color[9*int'(pick) +: 9];
                ox_n = nX'(X_FIRST + int'(pick) * X_PITCH - BOX_SIZE / 2);
                cx_n = '0;
                cy_n = '0;
            end
            DRAW: begin
                write_n = 1'b1;
                x_n = ox + nX'(cx);
                y_n = OY + nY'(cy);
                color_n = col;
                cx_n = cx + 1'b1;
                cy_n = &cx ? cy + 1'b1 : cy;
                state_n = (&cx && &cy) ? ACK : DRAW;
            end
            ACK: begin
                ack_n[bus.grant_id] = 1'b1;
                ptr_n = (int'(bus.grant_id) == NBOX - 1) ? 3'd0 : bus.grant_id + 3'd1;
                state_n = IDLE;
            end
`ifdef CLEAR_SCREEN_EN
            CLEAR: begin
                write_n = 1'b1;
                x_n = px;
                y_n = py;
                color_n = '0;
                gid_n = '0;
                px_n = (int'(px) == SCREEN_W - 1) ? '0 : px + 1'b1;
                py_n = (int'(px) == SCREEN_W - 1) ? py + 1'b1 : py;
                state_n = (int'(px) == SCREEN_W - 1 && int'(py) == SCREEN_H - 1) ? IDLE : CLEAR;
            end
`endif
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RST_STATE;
            ptr <= '0;
            col <= '0;
            ox <= '0;
            cx <= '0;
            cy <= '0;
            bus.grant_id <= '0;
            bus.x <= '0;
            bus.y <= '0;
            bus.color <= '0;
            bus.write <= 1'b0;
            bus.ack <= '0;
            bus.busy <= 1'b0;
`ifdef CLEAR_SCREEN_EN
            px <= '0;
            py <= '0;
`endif
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            col <= col_n;
            ox <= ox_n;
            cx <= cx_n;
            cy <= cy_n;
            bus.grant_id <= gid_n;
            bus.x <= x_n;
            bus.y <= y_n;
            bus.color <= color_n;
            bus.write <= write_n;
            bus.ack <= ack_n;
            bus.busy <= state != IDLE;
`ifdef CLEAR_SCREEN_EN
            px <= px_n;
            py <= py_n;
`endif
        end
    end
endmodule

// File: tb/tb_box_draw_scheduler.sv
// tb_box_draw_scheduler: directed checks of box_draw_scheduler with BOX_SIZE=4 and an 8x4 clear screen
module tb_box_draw_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int wx[$], wy[$], wc[$], wt[$], ak[$], at[$];
`ifdef CLEAR_SCREEN_EN
    localparam int CLR = 32;
`else
    localparam int CLR = 0;
`endif
    box_draw_scheduler_if #(.NBOX(8), .nX(10), .nY(9)) bus ();
    box_draw_scheduler #(.BOX_SIZE(4), .SCREEN_W(8), .SCREEN_H(4)) dut (.clock(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always begin
        @(posedge clk);
        #1;
        if (bus.write === 1'b1) begin
            wx.push_back(int'(bus.x));
            wy.push_back(int'(bus.y));
            wc.push_back(int'(bus.color));
            wt.push_back(cyc);
        end
        if ((|bus.ack) === 1'b1) begin
            ak.push_back(int'(bus.ack));
            at.push_back(cyc);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wx.delete(); wy.delete(); wc.delete(); wt.delete(); ak.delete(); at.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_cyc(cyc + CLR + 1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        bus.req_color = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.ack !== 8'h00) begin n_fail++; $display("FAIL reset_ack got %h want 00", bus.ack); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", bus.grant_id); end
        n_checks++; if ({bus.x, bus.y, bus.color} !== 28'd0) begin n_fail++; $display("FAIL reset_xyc got %0d,%0d,%h want 0,0,000", bus.x, bus.y, bus.color); end
        n_checks++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", bus.write); end
        reset = 1'b0;
        wait_cyc(cyc + CLR + 1);
    endtask

    task automatic test_single();
        int c;
        clear_logs();
        @(negedge clk);
        c = cyc;
        bus.req_color[8:0] = 9'h070;
        bus.req = 8'h01;
        wait_cyc(c + 18);
        n_checks++; if (bus.ack !== 8'h01) begin n_fail++; $display("FAIL single_ack got %h want 01", bus.ack); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_ack got %b want 1", bus.busy); end
        bus.req = '0;
        wait_cyc(c + 19);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", bus.busy); end
        n_checks++; if (bus.x !== 10'd41 || bus.y !== 9'd241 || bus.color !== 9'h070) begin n_fail++; $display("FAIL single_hold got %0d,%0d,%h want 41,241,070", bus.x, bus.y, bus.color); end
        n_checks++; if (wx.size() != 16) begin n_fail++; $display("FAIL single_count got %0d want 16", wx.size()); end
        for (int k = 0; k < 16 && k < wx.size(); k++) begin
            n_checks++;
            if (wx[k] != 38 + k % 4 || wy[k] != 238 + k / 4 || wc[k] != 'h070 || wt[k] != c + 2 + k) begin
                n_fail++;
                $display("FAIL single_px%0d got x=%0d y=%0d c=%h t=%0d want x=%0d y=%0d c=070 t=%0d", k, wx[k], wy[k], wc[k], wt[k], 38 + k % 4, 238 + k / 4, c + 2 + k);
            end
        end
        n_checks++; if (at.size() != 1 || at[0] != c + 18) begin n_fail++; $display("FAIL single_ack_time got n=%0d want one ack at %0d", at.size(), c + 18); end
    endtask

    task automatic test_round_robin();
        int c;
        do_reset();
        clear_logs();
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < 8; i++) bus.req_color[9*i +: 9] = 9'(i + 1);
        bus.req = 8'hFF;
        wait_cyc(c + 2 + 18 * 8 + 1);
        bus.req = '0;
        wait_cyc(c + 18 + 18 * 8 + 2);
        n_checks++; if (wx.size() != 16 * 9) begin n_fail++; $display("FAIL rr_count got %0d want 144", wx.size()); end
        for (int i = 0; i < 9 && 16 * i < wx.size(); i++) begin
            n_checks++;
            if (wx[16*i] != 38 + 80 * (i % 8) || wy[16*i] != 238 || wc[16*i] != i % 8 + 1 || wt[16*i] != c + 2 + 18 * i) begin
                n_fail++;
                $display("FAIL rr_first%0d got x=%0d y=%0d c=%0d t=%0d want x=%0d y=238 c=%0d t=%0d", i, wx[16*i], wy[16*i], wc[16*i], wt[16*i], 38 + 80 * (i % 8), i % 8 + 1, c + 2 + 18 * i);
            end
        end
        n_checks++; if (ak.size() != 9) begin n_fail++; $display("FAIL rr_acks got %0d want 9", ak.size()); end
        for (int i = 0; i < 9 && i < ak.size(); i++) begin
            n_checks++; if (ak[i] != 1 << (i % 8)) begin n_fail++; $display("FAIL rr_order%0d got %h want %h", i, ak[i], 1 << (i % 8)); end
        end
    endtask

    task automatic test_color_latch();
        int c;
        clear_logs();
        @(negedge clk);
        c = cyc;
        bus.req_color[26:18] = 9'h1C0;
        bus.req = 8'h04;
        wait_cyc(c + 4);
        bus.req_color[26:18] = 9'h007;
        bus.req = '0;
        wait_cyc(c + 19);
        n_checks++; if (wx.size() != 16) begin n_fail++; $display("FAIL latch_count got %0d want 16", wx.size()); end
        n_checks++; if (wx.size() > 0 && wx[0] != 198) begin n_fail++; $display("FAIL latch_x0 got %0d want 198", wx[0]); end
        for (int k = 0; k < wc.size(); k++) begin
            n_checks++; if (wc[k] != 'h1C0) begin n_fail++; $display("FAIL latch_color%0d got %h want 1c0", k, wc[k]); end
        end
        n_checks++; if (ak.size() != 1 || ak[0] != 'h04 || at[0] != c + 18) begin n_fail++; $display("FAIL latch_ack got n=%0d want one 04 at %0d", ak.size(), c + 18); end
    endtask

    task automatic test_reset_mid_draw();
        int c, g;
        clear_logs();
        @(negedge clk);
        c = cyc;
        bus.req = 8'h08;
        wait_cyc(c + 6);
        n_checks++; if (bus.write !== 1'b1 || bus.x !== 10'd278 || bus.y !== 9'd239) begin n_fail++; $display("FAIL mid_5th got w=%b %0d,%0d want 1 278,239", bus.write, bus.x, bus.y); end
        reset = 1'b1;
        bus.req = 8'h18;
        wait_cyc(c + 7);
        n_checks++; if (bus.write !== 1'b0 || bus.ack !== 8'h00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset got w=%b a=%h b=%b want 0 00 0", bus.write, bus.ack, bus.busy); end
        reset = 1'b0;
        g = c + 8 + CLR;
        wait_cyc(g);
        n_checks++; if (bus.grant_id !== 3'd3) begin n_fail++; $display("FAIL mid_regrant got %0d want 3", bus.grant_id); end
        wait_cyc(g + 1);
        n_checks++; if (bus.write !== 1'b1 || bus.x !== 10'd278 || bus.y !== 9'd238) begin n_fail++; $display("FAIL mid_first got w=%b %0d,%0d want 1 278,238", bus.write, bus.x, bus.y); end
        wait_cyc(g + 17);
        n_checks++; if (bus.ack !== 8'h08) begin n_fail++; $display("FAIL mid_ack3 got %h want 08", bus.ack); end
        bus.req = 8'h10;
        wait_cyc(g + 35);
        n_checks++; if (bus.ack !== 8'h10) begin n_fail++; $display("FAIL mid_ack4 got %h want 10", bus.ack); end
        bus.req = '0;
        wait_cyc(g + 37);
        n_checks++; if (ak.size() != 2 || ak[0] != 'h08 || ak[1] != 'h10) begin n_fail++; $display("FAIL mid_acklog got n=%0d want 08,10 only", ak.size()); end
    endtask

    task automatic test_priority_wrap();
        int c;
        clear_logs();
        @(negedge clk);
        c = cyc;
        bus.req = 8'h01;
        wait_cyc(c + 18);
        n_checks++; if (bus.ack !== 8'h01) begin n_fail++; $display("FAIL wrap_ack0 got %h want 01", bus.ack); end
        bus.req = 8'h81;
        wait_cyc(c + 19);
        n_checks++; if (bus.grant_id !== 3'd7) begin n_fail++; $display("FAIL wrap_grant7 got %0d want 7", bus.grant_id); end
        wait_cyc(c + 20);
        n_checks++; if (bus.write !== 1'b1 || bus.x !== 10'd598) begin n_fail++; $display("FAIL wrap_x7 got w=%b x=%0d want 1 598", bus.write, bus.x); end
        wait_cyc(c + 36);
        n_checks++; if (bus.ack !== 8'h80) begin n_fail++; $display("FAIL wrap_ack7 got %h want 80", bus.ack); end
        bus.req = 8'h01;
        wait_cyc(c + 37);
        n_checks++; if (bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL wrap_grant0 got %0d want 0", bus.grant_id); end
        wait_cyc(c + 54);
        n_checks++; if (bus.ack !== 8'h01) begin n_fail++; $display("FAIL wrap_ack0b got %h want 01", bus.ack); end
        bus.req = '0;
        wait_cyc(c + 56);
        n_checks++; if (ak.size() != 3) begin n_fail++; $display("FAIL wrap_acklog got %0d want 3", ak.size()); end
    endtask

`ifdef CLEAR_SCREEN_EN
    task automatic test_clear();
        int r;
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        bus.req_color[8:0] = 9'h1FF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        r = cyc;
        @(negedge clk);
        bus.req = 8'h01;
        for (int t = r + 1; t <= r + 32; t++) begin
            wait_cyc(t);
            n_checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL clear_busy@%0d got b=%b g=%0d want 1 0", t - r, bus.busy, bus.grant_id); end
        end
        wait_cyc(r + 34);
        n_checks++; if (bus.write !== 1'b1 || bus.x !== 10'd38 || bus.color !== 9'h1FF) begin n_fail++; $display("FAIL clear_then_box got w=%b x=%0d c=%h want 1 38 1ff", bus.write, bus.x, bus.color); end
        wait_cyc(r + 50);
        n_checks++; if (bus.ack !== 8'h01) begin n_fail++; $display("FAIL clear_ack got %h want 01", bus.ack); end
        bus.req = '0;
        wait_cyc(r + 52);
        n_checks++; if (wx.size() != 48) begin n_fail++; $display("FAIL clear_count got %0d want 48", wx.size()); end
        for (int k = 0; k < 32 && k < wx.size(); k++) begin
            n_checks++;
            if (wx[k] != k % 8 || wy[k] != k / 8 || wc[k] != 0 || wt[k] != r + 1 + k) begin
                n_fail++;
                $display("FAIL clear_px%0d got x=%0d y=%0d c=%h t=%0d want x=%0d y=%0d c=0 t=%0d", k, wx[k], wy[k], wc[k], wt[k], k % 8, k / 8, r + 1 + k);
            end
        end
        n_checks++; if (ak.size() != 1) begin n_fail++; $display("FAIL clear_acklog got %0d want 1", ak.size()); end
    endtask
`endif

    initial begin
        bus.req = '0;
        bus.req_color = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_color_latch();
        test_reset_mid_draw();
        test_priority_wrap();
`ifdef CLEAR_SCREEN_EN
        test_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
